// File: rtl/calculator.sv
// 4-bit sign-magnitude add/sub/mul/div unit with start/busy/done handshake.
// Define CALC_SAT_EN to saturate Q to 15 on overflow (default: wrap).
module calculator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       signA,
  input  logic [3:0] A,
  input  logic       signB,
  input  logic [3:0] B,
  input  logic [1:0] sel,
  output logic       signQ,
  output logic [3:0] Q,
  output logic       ovf,
  output logic       dz,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    S_IDLE,
    S_DIV
  } state_t;

  state_t     r_state;
  logic [4:0] r_rem;
  logic [3:0] r_quo;
  logic [3:0] r_dvs;
  logic [1:0] r_cnt;
  logic       r_sgn;

  logic       w_sb;
  logic       w_sgn;
  logic [7:0] w_mag;
  logic       w_ovf;
  logic [3:0] w_q;
  logic       w_sq;
  logic       w_div;
  logic [4:0] w_shift;
  logic       w_ge;
  logic [4:0] w_rem_n;
  logic [3:0] w_quo_n;

  // Single-cycle path: subtract is add with B's sign flipped.
  always_comb begin
    w_sb  = signB ^ (sel == 2'b01);
    w_mag = 8'd0;
    w_sgn = 1'b0;
    if (sel[1]) begin
      w_mag = {4'd0, A} * {4'd0, B};
      w_sgn = signA ^ signB;
    end else if (signA == w_sb) begin
      w_mag = {4'd0, A} + {4'd0, B};
      w_sgn = signA;
    end else if (A >= B) begin
      w_mag = {4'd0, A - B};
      w_sgn = signA;
    end else begin
      w_mag = {4'd0, B - A};
      w_sgn = w_sb;
    end
    w_ovf = (w_mag > 8'd15);
`ifdef CALC_SAT_EN
    w_q   = w_ovf ? 4'd15 : w_mag[3:0];
`else
    w_q   = w_mag[3:0];
`endif
    w_sq  = w_sgn & (w_mag != 8'd0);
  end

  assign w_div = (sel == 2'b11);

  // Restoring divide: dividend shifts out of r_quo as quotient shifts in.
  always_comb begin
    w_shift = {r_rem[3:0], r_quo[3]};
    w_ge    = (w_shift >= {1'b0, r_dvs});
    w_rem_n = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
    w_quo_n = {r_quo[2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= 5'd0;
      r_quo   <= 4'd0;
      r_dvs   <= 4'd0;
      r_cnt   <= 2'd0;
      r_sgn   <= 1'b0;
      signQ   <= 1'b0;
      Q       <= 4'd0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_div && (B != 4'd0)) begin
              r_state <= S_DIV;
              busy    <= 1'b1;
              r_rem   <= 5'd0;
              r_quo   <= A;
              r_dvs   <= B;
              r_cnt   <= 2'd0;
              r_sgn   <= signA ^ signB;
            end else if (w_div) begin
              signQ <= 1'b0;
              Q     <= 4'd15;
              ovf   <= 1'b0;
              dz    <= 1'b1;
              done  <= 1'b1;
            end else begin
              signQ <= w_sq;
              Q     <= w_q;
              ovf   <= w_ovf;
              dz    <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_n;
          r_quo <= w_quo_n;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            signQ   <= r_sgn & (w_quo_n != 4'd0);
            Q       <= w_quo_n;
            ovf     <= 1'b0;
            dz      <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calculator.sv
// Scoreboard bench for calculator: random ops vs integer reference model.
// Honours CALC_SAT_EN like the design.
module tb_calculator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       signA = 1'b0;
  logic [3:0] A = 4'd0;
  logic       signB = 1'b0;
  logic [3:0] B = 4'd0;
  logic [1:0] sel = 2'd0;
  logic       signQ;
  logic [3:0] Q;
  logic       ovf;
  logic       dz;
  logic       busy;
  logic       done;

  typedef struct {
    int sq;
    int q;
    int ovf;
    int dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  calculator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .signA (signA),
    .A     (A),
    .signB (signB),
    .B     (B),
    .sel   (sel),
    .signQ (signQ),
    .Q     (Q),
    .ovf   (ovf),
    .dz    (dz),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer arithmetic, then sign/magnitude.
  function automatic exp_t model(input bit sa, input int a, input bit sb,
                                 input int b, input int s);
    exp_t e;
    int x, y, r, mag;
    x = sa ? -a : a;
    y = sb ? -b : b;
    if (s == 3 && b == 0) begin
      e.sq = 0; e.q = 15; e.ovf = 0; e.dz = 1;
      return e;
    end
    case (s)
      0: r = x + y;
      1: r = x - y;
      2: r = x * y;
      default: r = x / y;
    endcase
    mag   = (r < 0) ? -r : r;
    e.sq  = (r < 0) ? 1 : 0;
    e.ovf = (mag > 15) ? 1 : 0;
    e.dz  = 0;
`ifdef CALC_SAT_EN
    e.q   = (mag > 15) ? 15 : mag;
`else
    e.q   = mag % 16;
`endif
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("signQ", int'(signQ), e.sq);
        chk("Q", int'(Q), e.q);
        chk("ovf", int'(ovf), e.ovf);
        chk("dz", int'(dz), e.dz);
      end
    end
  end

  task automatic do_op(input bit sa, input int a, input bit sbb, input int b,
                       input int s, input bit disturb);
    int lat;
    int exp_lat;
    exp_lat = (s == 3 && b != 0) ? 5 : 1;
    @(negedge clk);
    signA = sa; A = 4'(a); signB = sbb; B = 4'(b); sel = 2'(s);
    start = 1'b1;
    sb_q.push_back(model(sa, a, sbb, b, s));
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin
      chk("busy_during_div", int'(busy), 1);
      @(negedge clk);
      if (disturb && lat == 1) begin
        signA = 1'($urandom); A = 4'($urandom); signB = 1'($urandom);
        B = 4'($urandom); sel = 2'($urandom); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("busy_at_done", int'(busy), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
  endtask

  task automatic reset_abort();
    @(negedge clk);
    signA = 1'b0; A = 4'd13; signB = 1'b0; B = 4'd3; sel = 2'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy", int'(busy), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", int'({signQ, Q, ovf, dz, busy, done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_hold_Q", int'(Q), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_outs", int'({signQ, Q, ovf, dz, busy, done}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 3, 0, 4, 0, 0);
    do_op(1, 5, 0, 7, 1, 0);
    do_op(1, 5, 0, 7, 2, 0);
    do_op(0, 13, 1, 4, 3, 1);
    do_op(0, 9, 0, 0, 3, 0);
    do_op(0, 5, 1, 5, 0, 0);
    do_op(1, 0, 0, 0, 0, 0);
    do_op(0, 15, 0, 15, 0, 0);
    do_op(1, 15, 1, 15, 2, 0);
    do_op(1, 0, 0, 7, 3, 0);
    do_op(1, 15, 0, 1, 3, 0);
    reset_abort();
    do_op(0, 7, 0, 2, 3, 0);

    for (int i = 0; i < 300; i++) begin
      do_op(1'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
            1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
